// File: rtl/adpll_pkg.sv
// adpll_pkg: shared state encoding, default constants and saturating magnitude helper for the ADPLL lock detector
package adpll_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SEARCH   = 2'd1,
    ST_LOCKED   = 2'd2,
    ST_SLIPPING = 2'd3
  } state_t;

  localparam int ERR_WIDTH_DEF     = 8;
  localparam int LOCK_THRESH_DEF   = 2;
  localparam int UNLOCK_THRESH_DEF = 6;
  localparam int LOCK_COUNT_DEF    = 16;
  localparam int UNLOCK_COUNT_DEF  = 4;
  localparam int REF_TIMEOUT_DEF   = 1024;
  localparam int CNT_WIDTH_DEF     = 11;

  // |e| for a w-bit two's complement value; the most negative code saturates to the largest positive code
  function automatic logic [31:0] abs_sat(input logic signed [31:0] e, input int w);
    logic [31:0] a;
    logic [31:0] m;
    a = e[31] ? 32'(-e) : 32'(e);
    m = (32'd1 << (w - 1)) - 32'd1;
    return (a > m) ? m : a;
  endfunction

endpackage

// File: rtl/ref_edge_sync.sv
// ref_edge_sync: two-flop synchroniser plus rising-edge strobe for an asynchronous level input
module ref_edge_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_rise
);

  logic [2:0] r_sh;

  // two metastability flops followed by a history flop for edge detection
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_sh <= '0;
    else r_sh <= {r_sh[1:0], i_async};
  end

  assign o_rise = r_sh[1] & ~r_sh[2];

endmodule

// File: rtl/adpll_lock_detect.sv
// adpll_lock_detect: lock qualification with hysteresis and reference watchdog; define ADPLL_LOCK_DET_PEAK_EN to build the peak-error tracker
module adpll_lock_detect
  import adpll_pkg::*;
#(
  parameter int ERR_WIDTH     = ERR_WIDTH_DEF,
  parameter int LOCK_THRESH   = LOCK_THRESH_DEF,
  parameter int UNLOCK_THRESH = UNLOCK_THRESH_DEF,
  parameter int LOCK_COUNT    = LOCK_COUNT_DEF,
  parameter int UNLOCK_COUNT  = UNLOCK_COUNT_DEF,
  parameter int REF_TIMEOUT   = REF_TIMEOUT_DEF,
  parameter int CNT_WIDTH     = CNT_WIDTH_DEF
) (
  input  logic                        fpga_clk_i,
  input  logic                        reset_i,
  input  logic                        enable_i,
  input  logic                        ref_clk_i,
  input  logic signed [ERR_WIDTH-1:0] error_i,
  output logic                        locked_o,
  output logic                        lock_lost_o,
  output logic                        ref_lost_o,
  output logic [1:0]                  state_o,
  output logic [ERR_WIDTH-1:0]        max_abs_err_o
);

  localparam logic [ERR_WIDTH-1:0] LK_TH   = ERR_WIDTH'(LOCK_THRESH);
  localparam logic [ERR_WIDTH-1:0] UL_TH   = ERR_WIDTH'(UNLOCK_THRESH);
  localparam logic [CNT_WIDTH-1:0] LK_CNT  = CNT_WIDTH'(LOCK_COUNT);
  localparam logic [CNT_WIDTH-1:0] UL_CNT  = CNT_WIDTH'(UNLOCK_COUNT);
  localparam logic [CNT_WIDTH-1:0] WD_MAX  = CNT_WIDTH'(REF_TIMEOUT);
  localparam logic [CNT_WIDTH-1:0] WD_LAST = CNT_WIDTH'(REF_TIMEOUT - 1);

  logic                 w_strobe;
  logic                 w_expire;
  logic                 w_in;
  logic                 w_miss;
  logic                 w_lost_nxt;
  logic                 r_valid;
  logic                 r_ref_lost;
  logic                 r_lock_lost;
  logic [ERR_WIDTH-1:0] r_abs;
  logic [CNT_WIDTH-1:0] r_wd;
  logic [CNT_WIDTH-1:0] r_lock_cnt;
  logic [CNT_WIDTH-1:0] r_miss_cnt;
  logic [CNT_WIDTH-1:0] w_lock_nxt;
  logic [CNT_WIDTH-1:0] w_miss_nxt;
  state_t               r_state;
  state_t               w_state_nxt;

  ref_edge_sync u_sync (
    .i_clk   (fpga_clk_i),
    .i_rst   (reset_i),
    .i_async (ref_clk_i),
    .o_rise  (w_strobe)
  );

  assign w_in     = r_abs <= LK_TH;
  assign w_miss   = r_abs > UL_TH;
  assign w_expire = enable_i && !w_strobe && (r_wd == WD_LAST);

  // capture the error magnitude on the strobe; the FSM consumes it one cycle later
  always_ff @(posedge fpga_clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_valid <= 1'b0;
      r_abs   <= '0;
    end else begin
      r_valid <= w_strobe;
      if (w_strobe) r_abs <= ERR_WIDTH'(abs_sat(32'(error_i), ERR_WIDTH));
    end
  end

  // reference watchdog: counts idle cycles between strobes and flags expiry until the next strobe
  always_ff @(posedge fpga_clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_wd       <= '0;
      r_ref_lost <= 1'b0;
    end else begin
      r_wd       <= (!enable_i || w_strobe) ? '0 : (r_wd == WD_MAX) ? r_wd : r_wd + 1'b1;
      r_ref_lost <= (!enable_i || w_strobe) ? 1'b0 : (w_expire ? 1'b1 : r_ref_lost);
    end
  end

  // state and counter registers
  always_ff @(posedge fpga_clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state     <= ST_IDLE;
      r_lock_cnt  <= '0;
      r_miss_cnt  <= '0;
      r_lock_lost <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_lock_cnt  <= w_lock_nxt;
      r_miss_cnt  <= w_miss_nxt;
      r_lock_lost <= w_lost_nxt;
    end
  end

  // next state: disable beats watchdog expiry, which beats sample evaluation
  always_comb begin
    w_state_nxt = r_state;
    w_lock_nxt  = r_lock_cnt;
    w_miss_nxt  = r_miss_cnt;
    w_lost_nxt  = 1'b0;
    if (!enable_i) begin
      w_state_nxt = ST_IDLE;
      w_lock_nxt  = '0;
      w_miss_nxt  = '0;
    end else if (w_expire) begin
      w_state_nxt = ST_SEARCH;
      w_lock_nxt  = '0;
      w_miss_nxt  = '0;
      w_lost_nxt  = r_state[1];
    end else if (r_state == ST_IDLE) begin
      w_state_nxt = ST_SEARCH;
      w_lock_nxt  = '0;
      w_miss_nxt  = '0;
    end else if (r_valid) begin
      case (r_state)
        ST_SEARCH: begin
          w_lock_nxt = w_in ? r_lock_cnt + 1'b1 : '0;
          if (w_in && (r_lock_cnt + 1'b1 == LK_CNT)) begin
            w_state_nxt = ST_LOCKED;
            w_lock_nxt  = '0;
          end
        end
        ST_LOCKED: begin
          if (w_miss) begin
            w_state_nxt = ST_SLIPPING;
            w_miss_nxt  = CNT_WIDTH'(1);
          end
        end
        ST_SLIPPING: begin
          if (w_miss) begin
            w_miss_nxt = r_miss_cnt + 1'b1;
            if (r_miss_cnt + 1'b1 >= UL_CNT) begin
              w_state_nxt = ST_SEARCH;
              w_miss_nxt  = '0;
              w_lock_nxt  = '0;
              w_lost_nxt  = 1'b1;
            end
          end else if (w_in) begin
            w_state_nxt = ST_LOCKED;
            w_miss_nxt  = '0;
          end
        end
        default: ;
      endcase
    end
  end

  // status outputs decoded from registered state
  always_comb begin
    locked_o    = r_state[1];
    lock_lost_o = r_lock_lost;
    ref_lost_o  = r_ref_lost;
    state_o     = r_state;
  end

`ifdef ADPLL_LOCK_DET_PEAK_EN
  logic                 w_eval;
  logic [ERR_WIDTH-1:0] r_peak;

  assign w_eval = r_valid && enable_i && !w_expire;

  // peak magnitude while locked, restarted on each fresh lock
  always_ff @(posedge fpga_clk_i or posedge reset_i) begin
    if (reset_i) r_peak <= '0;
    else if (r_state == ST_SEARCH && w_state_nxt == ST_LOCKED) r_peak <= '0;
    else if (w_eval && r_state[1] && r_abs > r_peak) r_peak <= r_abs;
  end

  assign max_abs_err_o = r_peak;
`else
  assign max_abs_err_o = '0;
`endif

endmodule

// File: tb/tb_adpll_lock_detect.sv
// tb_adpll_lock_detect: randomized self-checking bench with a per-reference-sample behavioural model
module tb_adpll_lock_detect;

  localparam int LT = 2;
  localparam int UT = 6;
  localparam int LC = 16;
  localparam int UC = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              en = 1'b0;
  logic              ref_clk = 1'b0;
  logic signed [7:0] err = '0;
  logic              locked_o;
  logic              lock_lost_o;
  logic              ref_lost_o;
  logic [1:0]        state_o;
  logic [7:0]        max_abs_err_o;

  int n_chk = 0;
  int n_err = 0;
  int m_state = 0;
  int m_lock = 0;
  int m_miss = 0;
  int m_peak = 0;
  int m_pulse = 0;

  adpll_lock_detect dut (
    .fpga_clk_i    (clk),
    .reset_i       (rst),
    .enable_i      (en),
    .ref_clk_i     (ref_clk),
    .error_i       (err),
    .locked_o      (locked_o),
    .lock_lost_o   (lock_lost_o),
    .ref_lost_o    (ref_lost_o),
    .state_o       (state_o),
    .max_abs_err_o (max_abs_err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int exp_peak();
`ifdef ADPLL_LOCK_DET_PEAK_EN
    return m_peak;
`else
    return 0;
`endif
  endfunction

  task automatic model_sample(input int e);
    int a;
    a = (e < 0) ? ((e == -128) ? 127 : -e) : e;
    m_pulse = 0;
    if (m_state >= 2 && a > m_peak) m_peak = a;
    if (m_state == 1) begin
      if (a <= LT) begin
        m_lock++;
        if (m_lock == LC) begin
          m_state = 2;
          m_lock = 0;
          m_peak = 0;
        end
      end else m_lock = 0;
    end else if (m_state == 2) begin
      if (a > UT) begin
        m_state = 3;
        m_miss = 1;
      end
    end else if (m_state == 3) begin
      if (a > UT) begin
        m_miss++;
        if (m_miss == UC) begin
          m_state = 1;
          m_miss = 0;
          m_lock = 0;
          m_pulse = 1;
        end
      end else if (a <= LT) begin
        m_state = 2;
        m_miss = 0;
      end
    end
  endtask

  function automatic int rnd_err(input int p_in, input int p_mid);
    int r;
    int m;
    r = int'($urandom_range(99));
    if (r < p_in) return int'($urandom_range(4)) - 2;
    m = (r < p_in + p_mid) ? 3 + int'($urandom_range(3)) : 7 + int'($urandom_range(121));
    if (m == 128) return -128;
    return $urandom_range(1) ? -m : m;
  endfunction

  task automatic ref_period(input int e);
    @(negedge clk);
    err = 8'(e);
    ref_clk = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("pre_state", int'(state_o), m_state);
    chk("ref_lost_clr", int'(ref_lost_o), 0);
    @(posedge clk);
    #1;
    model_sample(e);
    chk("state", int'(state_o), m_state);
    chk("locked", int'(locked_o), (m_state >= 2) ? 1 : 0);
    chk("lock_lost", int'(lock_lost_o), m_pulse);
    chk("peak", int'(max_abs_err_o), exp_peak());
    @(posedge clk);
    #1;
    chk("pulse_width", int'(lock_lost_o), 0);
    repeat (8) @(negedge clk);
    ref_clk = 1'b0;
    repeat (13) @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_locked"}, int'(locked_o), 0);
    chk({tag, "_lost"}, int'(lock_lost_o), 0);
    chk({tag, "_ref"}, int'(ref_lost_o), 0);
    chk({tag, "_state"}, int'(state_o), 0);
    chk({tag, "_peak"}, int'(max_abs_err_o), 0);
  endtask

  initial begin
    #1 rst = 1'b1;
    #2 chk_all_zero("reset");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1 chk("idle", int'(state_o), 0);
    @(negedge clk);
    en = 1'b1;
    @(posedge clk);
    #1;
    m_state = 1;
    chk("search", int'(state_o), 1);

    repeat (LC) ref_period(1);
    chk("basic_lock", int'(locked_o), 1);
    repeat (20) ref_period(5);
    repeat (3) ref_period(-9);
    ref_period(0);
    chk("slip_recover", int'(state_o), 2);
    repeat (4) ref_period(-9);
    chk("unlock", int'(state_o), 1);
    repeat (LC) ref_period(0);
    ref_period(-128);
    ref_period(0);
    repeat (4) ref_period(-9);
    repeat (LC) ref_period(1);

    repeat (100) ref_period(rnd_err(95, 3));
    repeat (100) ref_period(rnd_err(60, 15));
    repeat (LC) ref_period(0);
    chk("relock", int'(state_o), 2);

    @(negedge clk);
    err = '0;
    ref_clk = 1'b1;
    for (int i = 1; i <= 1028; i++) begin
      @(posedge clk);
      #1;
      if (i == 4) model_sample(0);
      if (i == 1026) begin
        chk("wd_pre_ref", int'(ref_lost_o), 0);
        chk("wd_pre_state", int'(state_o), 2);
      end
      if (i == 1027) begin
        chk("wd_ref_lost", int'(ref_lost_o), 1);
        chk("wd_lock_lost", int'(lock_lost_o), 1);
        chk("wd_state", int'(state_o), 1);
      end
      if (i == 1028) chk("wd_pulse_end", int'(lock_lost_o), 0);
    end
    m_state = 1;
    m_lock = 0;
    m_miss = 0;
    @(negedge clk);
    ref_clk = 1'b0;
    repeat (10) @(negedge clk);
    chk("wd_hold", int'(ref_lost_o), 1);
    repeat (LC) ref_period(2);

    @(negedge clk);
    en = 1'b0;
    @(posedge clk);
    #1;
    chk("dis_state", int'(state_o), 0);
    chk("dis_lost", int'(lock_lost_o), 0);
    @(posedge clk);
    #1 chk("dis_lost2", int'(lock_lost_o), 0);
    m_state = 0;
    m_lock = 0;
    m_miss = 0;
    @(negedge clk);
    en = 1'b1;
    @(posedge clk);
    #1;
    m_state = 1;
    chk("reen_search", int'(state_o), 1);
    repeat (LC) ref_period(-1);
    ref_period(100);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk_all_zero("async_rst");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/adpll_lock_detect.md
Name: adpll_lock_detect

Overview:
- Sits directly downstream of the ADPLL and consumes its signed phase-error output.
- Samples the error once per reference period and qualifies lock with hysteresis thresholds and consecutive-sample counters.
- Flags loss of the reference clock with a watchdog.
- Drives status LEDs and gates downstream use of the generated clock; runs in the fast fabric clock domain (258 MHz).

Parameters:
- ERR_WIDTH, 8, width of signed phase-error input.
- LOCK_THRESH, 2, |error| at or below this counts as in-window.
- UNLOCK_THRESH, 6, |error| above this counts as a miss (must be >= LOCK_THRESH).
- LOCK_COUNT, 16, consecutive in-window samples required to declare lock.
- UNLOCK_COUNT, 4, consecutive misses required to drop lock.
- REF_TIMEOUT, 1024, fpga_clk_i cycles without a reference edge before the reference is declared lost.
- CNT_WIDTH, 11, width of internal counters; must hold REF_TIMEOUT.

Ports:
- fpga_clk_i  in  1  fabric clock, same as ADPLL.
- reset_i  in  1  asynchronous, active-high reset.
- enable_i  in  1  detector enable; low forces the IDLE state.
- ref_clk_i  in  1  reference clock, asynchronous to fpga_clk_i.
- error_i  in  ERR_WIDTH  signed phase error from the ADPLL (two's complement).
- locked_o  out  1  high in the LOCKED and SLIPPING states.
- lock_lost_o  out  1  one-cycle pulse on any exit from LOCKED or SLIPPING, except via enable_i low.
- ref_lost_o  out  1  high while the reference watchdog has expired.
- state_o  out  2  current FSM state, for debug and display.
- max_abs_err_o  out  ERR_WIDTH  peak |error| since the last lock (see Optional Feature).

Behaviour:
- Reset: all outputs 0, state IDLE, all counters 0, synchroniser flops 0.
- Reference path:
  - ref_clk_i passes through a 2-FF synchroniser followed by a rising-edge detect.
  - This produces a strobe on the 3rd fpga_clk_i rising edge after the ref rising edge.
  - error_i is registered on the strobe cycle. The FSM and counters update on the following cycle, so total latency is 4 cycles from ref edge to state change.
- Magnitude:
  - abs = error_i when non-negative, otherwise -error_i.
  - The most negative value (-128) saturates to 127.
  - Comparisons are unsigned on the abs value.
- Watchdog:
  - Counter increments every cycle while enabled and clears on each strobe.
  - At REF_TIMEOUT it saturates and ref_lost_o goes high.
  - The next strobe clears ref_lost_o.
- States (encoding 0..3):
  - IDLE:
    - Enters SEARCH when enable_i is high.
    - Counters are held at 0.
  - SEARCH:
    - In-window sample: lock counter +1.
    - Any other sample: lock counter cleared.
    - When the lock counter reaches LOCK_COUNT, go to LOCKED.
  - LOCKED:
    - A miss (abs > UNLOCK_THRESH) sets the miss counter to 1 and moves to SLIPPING.
    - Samples between the thresholds are ignored (hysteresis).
  - SLIPPING:
    - A miss increments the miss counter. When it reaches UNLOCK_COUNT, go to SEARCH and pulse lock_lost_o.
    - An in-window sample clears the miss counter and returns to LOCKED.
    - A sample between the thresholds holds the miss counter.
- Priority when events coincide in the same cycle:
  - enable_i low overrides everything: go to IDLE, clear counters, no lock_lost_o pulse.
  - Watchdog expiry next: go to SEARCH, clear counters, pulse lock_lost_o if leaving LOCKED or SLIPPING.
  - Sample evaluation last.
- Entering SEARCH from any state clears the lock counter.
- Counters saturate and never wrap.
- Asserting reset_i mid-operation returns the block to the reset state immediately, with no lock_lost_o pulse.

Optional Feature:
- Macro: ADPLL_LOCK_DET_PEAK_EN.
- With the macro defined:
  - max_abs_err_o holds the maximum abs seen on strobes while in LOCKED or SLIPPING.
  - It clears to 0 on entry to LOCKED from SEARCH, and holds its value after lock is lost until the next lock.
- Without the macro: max_abs_err_o is tied to 0 and the peak register is not built.

Decomposition:
- Shared package adpll_pkg holds:
  - the state enumeration (IDLE=0, SEARCH=1, LOCKED=2, SLIPPING=3);
  - default ERR_WIDTH and the threshold constants;
  - the signed-abs-with-saturation function.
- One natural sub-module: ref_edge_sync, containing the 2-FF synchroniser and rising-edge strobe generator; reusable on other asynchronous inputs.

Test Plan:
- Basic lock: reset, enable_i=1, 10 MHz ref, error_i=1 constant.
  - locked_o rises exactly 4 cycles after the 16th ref rising edge.
  - state_o steps 0->1->2.
- Hysteresis: while locked, drive error_i=5 for 20 ref periods.
  - locked_o stays 1, state_o=2, no lock_lost_o pulse.
- Unlock: while locked, drive error_i=-9 for 4 ref periods.
  - Sample 1 moves state_o to 3.
  - After sample 4, exactly one lock_lost_o pulse, locked_o=0, state_o=1.
  - With error_i=-9 for only 3 periods and then 0, the state returns to 2.
- Saturation/peak (macro defined): while locked, apply error_i=-128 once.
  - max_abs_err_o=127 and the miss counter increments.
  - Re-lock clears max_abs_err_o to 0.
- Reference loss: stop ref_clk_i while locked.
  - ref_lost_o rises at cycle 1024 with a simultaneous lock_lost_o pulse; state_o=1.
  - Restarting ref clears ref_lost_o on the first strobe.
- Enable/reset mid-lock: deassert enable_i while locked.
  - state_o=0 next cycle with no lock_lost_o pulse.
  - Asynchronous reset_i asserted between clock edges zeroes all outputs immediately.
